// File: rtl/sram_bus_ctrl.sv
// Registered wait-state controller between the b16 memory bus and a 16-bit async SRAM.
// Latches one request, drives glitch-free registered strobes, returns read data with ready.
module sram_bus_ctrl #(
  parameter int unsigned WAIT = 3
) (
  input  logic        clk,
  input  logic        nreset,
  input  logic        sel,
  input  logic        r,
  input  logic [1:0]  w,
  input  logic [15:0] addr,
  input  logic [2:0]  bank,
  input  logic [15:0] din,
  output logic [15:0] dout,
  output logic        ready,
  output logic [17:0] sram_addr,
  input  logic [15:0] sram_dq_in,
  output logic [15:0] sram_dq_out,
  output logic        sram_dq_oe,
  output logic        sram_ce_n,
  output logic        sram_oe_n,
  output logic        sram_we_n,
  output logic        sram_ub_n,
  output logic        sram_lb_n
);

  localparam int unsigned CNT_W    = 4;
  localparam int unsigned WAIT_EFF = (WAIT == 0) ? 1 : WAIT;

  typedef enum logic [1:0] {IDLE, ACCESS, HOLD, DONE} state_t;

  state_t             state, state_d;
  logic [CNT_W-1:0]   cnt, cnt_d;
  logic               wr, wr_d;
  logic [15:0]        dout_d, dq_out_d;
  logic [17:0]        addr_d;
  logic               dq_oe_d, ce_d, oe_d, we_d, ub_d, lb_d;
  logic               req, start;
  logic               unused;

  // Byte address bit 0 has no meaning on a 16-bit SRAM.
  assign unused = addr[0];

  assign req   = sel & (r | (|w));
  assign ready = ((state == IDLE) & ~req) | (state == DONE);

  always_ff @(posedge clk) begin
    if (!nreset) begin
      state       <= IDLE;
      cnt         <= '0;
      wr          <= 1'b0;
      dout        <= '0;
      sram_addr   <= '0;
      sram_dq_out <= '0;
      sram_dq_oe  <= 1'b0;
      sram_ce_n   <= 1'b1;
      sram_oe_n   <= 1'b1;
      sram_we_n   <= 1'b1;
      sram_ub_n   <= 1'b1;
      sram_lb_n   <= 1'b1;
    end else begin
      state       <= state_d;
      cnt         <= cnt_d;
      wr          <= wr_d;
      dout        <= dout_d;
      sram_addr   <= addr_d;
      sram_dq_out <= dq_out_d;
      sram_dq_oe  <= dq_oe_d;
      sram_ce_n   <= ce_d;
      sram_oe_n   <= oe_d;
      sram_we_n   <= we_d;
      sram_ub_n   <= ub_d;
      sram_lb_n   <= lb_d;
    end
  end

  // Next state plus next value of every registered pin.
  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    wr_d     = wr;
    dout_d   = dout;
    addr_d   = sram_addr;
    dq_out_d = sram_dq_out;
    dq_oe_d  = sram_dq_oe;
    ce_d     = sram_ce_n;
    oe_d     = sram_oe_n;
    we_d     = sram_we_n;
    ub_d     = sram_ub_n;
    lb_d     = sram_lb_n;
    start    = 1'b0;

    case (state)
      IDLE: start = req;
      ACCESS: begin
        if (cnt == '0) begin
          if (wr) begin
            // WE rises first; data and CE stay one more cycle for hold time.
            state_d = HOLD;
            we_d    = 1'b1;
          end else begin
            state_d = DONE;
            dout_d  = sram_dq_in;
            ce_d    = 1'b1;
            oe_d    = 1'b1;
            ub_d    = 1'b1;
            lb_d    = 1'b1;
          end
        end else begin
          cnt_d = cnt - CNT_W'(1);
        end
      end
      HOLD: begin
        state_d = DONE;
        ce_d    = 1'b1;
        we_d    = 1'b1;
        ub_d    = 1'b1;
        lb_d    = 1'b1;
        dq_oe_d = 1'b0;
      end
      DONE: begin
        start   = req;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Latch the request and assert strobes; write wins over read.
    if (start) begin
      state_d  = ACCESS;
      cnt_d    = CNT_W'(WAIT_EFF - 1);
      wr_d     = |w;
      addr_d   = {bank, addr[15:1]};
      dq_out_d = din;
      ce_d     = 1'b0;
      if (|w) begin
        oe_d    = 1'b1;
        we_d    = 1'b0;
        dq_oe_d = 1'b1;
        ub_d    = ~w[1];
        lb_d    = ~w[0];
      end else begin
        oe_d    = 1'b0;
        we_d    = 1'b1;
        dq_oe_d = 1'b0;
        ub_d    = 1'b0;
        lb_d    = 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sram_bus_ctrl.sv
// Directed bench for sram_bus_ctrl with WAIT=3: reset, reads, writes, abort and back-to-back.
module tb_sram_bus_ctrl;

  logic        clk = 1'b0;
  logic        nreset;
  logic        sel, r;
  logic [1:0]  w;
  logic [15:0] addr, din, sram_dq_in;
  logic [2:0]  bank;
  logic [15:0] dout, sram_dq_out;
  logic        ready, sram_dq_oe;
  logic [17:0] sram_addr;
  logic        sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n;
  logic [4:0]  strb;

  int vectors = 0;
  int miscompares = 0;

  sram_bus_ctrl #(.WAIT(3)) dut (
    .clk(clk), .nreset(nreset), .sel(sel), .r(r), .w(w), .addr(addr), .bank(bank),
    .din(din), .dout(dout), .ready(ready), .sram_addr(sram_addr),
    .sram_dq_in(sram_dq_in), .sram_dq_out(sram_dq_out), .sram_dq_oe(sram_dq_oe),
    .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n),
    .sram_ub_n(sram_ub_n), .sram_lb_n(sram_lb_n)
  );

  always #5 clk = ~clk;

  // {ce_n, oe_n, we_n, ub_n, lb_n}
  assign strb = {sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    nreset = 1'b0; sel = 1'b1; r = 1'b1; w = 2'b00;
    addr = '0; bank = '0; din = '0; sram_dq_in = '0;

    // Reset with a request on the bus
    tick(); tick();
    chk("rst_strb", 32'(strb), 32'h1F);
    chk("rst_dq_oe", 32'(sram_dq_oe), 32'h0);
    chk("rst_dout", 32'(dout), 32'h0);
    chk("rst_addr", 32'(sram_addr), 32'h0);
    sel = 1'b0; r = 1'b0; #1;
    chk("rst_ready", 32'(ready), 32'h1);
    nreset = 1'b1;
    tick();

    // Read 4A02 bank 1
    sel = 1'b1; r = 1'b1; addr = 16'h4A02; bank = 3'b001; sram_dq_in = 16'hBEEF; #1;
    chk("rd_c0_ready", 32'(ready), 32'h0);
    chk("rd_c0_strb", 32'(strb), 32'h1F);
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk("rd_acc_strb", 32'(strb), 32'h04);
      chk("rd_acc_ready", 32'(ready), 32'h0);
      chk("rd_acc_dq_oe", 32'(sram_dq_oe), 32'h0);
    end
    chk("rd_addr", 32'(sram_addr), 32'h0A501);
    tick();
    chk("rd_done_ready", 32'(ready), 32'h1);
    chk("rd_done_strb", 32'(strb), 32'h1F);
    chk("rd_dout", 32'(dout), 32'hBEEF);
    sel = 1'b0; r = 1'b0;
    tick();
    chk("rd_idle_ready", 32'(ready), 32'h1);

    // Low-byte write; bus changes mid-access must be ignored
    sel = 1'b1; w = 2'b01; din = 16'h1234; addr = 16'h0010; bank = 3'b000; #1;
    chk("wl_c0_ready", 32'(ready), 32'h0);
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk("wl_acc_strb", 32'(strb), 32'h0A);
      chk("wl_acc_dq_oe", 32'(sram_dq_oe), 32'h1);
      chk("wl_acc_ready", 32'(ready), 32'h0);
      if (k == 2) begin
        din = 16'hFFFF; addr = 16'hFFFE; w = 2'b11;
      end
    end
    tick();
    chk("wl_hold_strb", 32'(strb), 32'h0E);
    chk("wl_hold_dq_oe", 32'(sram_dq_oe), 32'h1);
    chk("wl_hold_dq_out", 32'(sram_dq_out), 32'h1234);
    chk("wl_hold_addr", 32'(sram_addr), 32'h00008);
    chk("wl_hold_ready", 32'(ready), 32'h0);
    tick();
    chk("wl_done_ready", 32'(ready), 32'h1);
    chk("wl_done_strb", 32'(strb), 32'h1F);
    chk("wl_done_dq_oe", 32'(sram_dq_oe), 32'h0);
    chk("wl_dout", 32'(dout), 32'hBEEF);
    sel = 1'b0; w = 2'b00;
    tick();

    // Write with sel=0 never reaches the SRAM
    w = 2'b11; din = 16'h7777; #1;
    chk("nosel_ready", 32'(ready), 32'h1);
    tick();
    chk("nosel_strb", 32'(strb), 32'h1F);
    chk("nosel_dq_oe", 32'(sram_dq_oe), 32'h0);

    // r=1 together with w=11 is a full-word write
    sel = 1'b1; r = 1'b1; w = 2'b11; din = 16'hABCD; #1;
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk("wb_acc_strb", 32'(strb), 32'h08);
    end
    tick();
    chk("wb_hold_strb", 32'(strb), 32'h0C);
    chk("wb_hold_dq_out", 32'(sram_dq_out), 32'hABCD);
    tick();
    chk("wb_done_ready", 32'(ready), 32'h1);
    chk("wb_dout", 32'(dout), 32'hBEEF);
    sel = 1'b0; r = 1'b0; w = 2'b00;
    tick();

    // Reset in the 2nd ACCESS cycle of a read aborts it and clears dout
    sel = 1'b1; r = 1'b1; addr = 16'h0100; sram_dq_in = 16'h1111; #1;
    tick();
    tick();
    chk("ab_acc2_strb", 32'(strb), 32'h04);
    nreset = 1'b0;
    tick();
    nreset = 1'b1;
    sram_dq_in = 16'h5A5A;
    chk("ab_strb", 32'(strb), 32'h1F);
    chk("ab_dq_oe", 32'(sram_dq_oe), 32'h0);
    chk("ab_dout", 32'(dout), 32'h0);
    chk("ab_ready", 32'(ready), 32'h0);
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk("ab_rd_ready", 32'(ready), 32'h0);
    end
    tick();
    chk("ab_rd_done_ready", 32'(ready), 32'h1);
    chk("ab_rd_dout", 32'(dout), 32'h5A5A);
    sel = 1'b0; r = 1'b0;
    tick();

    // Read, then a write presented in DONE starts with no IDLE gap
    sel = 1'b1; r = 1'b1; addr = 16'h0200; sram_dq_in = 16'hCAFE; #1;
    for (int k = 1; k <= 3; k++) tick();
    tick();
    chk("b2b_rd_ready", 32'(ready), 32'h1);
    chk("b2b_rd_dout", 32'(dout), 32'hCAFE);
    r = 1'b0; w = 2'b10; din = 16'h5555; #1;
    chk("b2b_done_ready", 32'(ready), 32'h1);
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk("b2b_wr_acc_strb", 32'(strb), 32'h09);
      chk("b2b_wr_acc_ready", 32'(ready), 32'h0);
    end
    tick();
    chk("b2b_wr_hold_strb", 32'(strb), 32'h0D);
    tick();
    chk("b2b_wr_done_strb", 32'(strb), 32'h1F);
    chk("b2b_wr_done_ready", 32'(ready), 32'h1);
    chk("b2b_wr_dout", 32'(dout), 32'hCAFE);
    sel = 1'b0; w = 2'b00;
    tick();
    chk("end_idle_ready", 32'(ready), 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
